// File: rtl/emif_wr_frontend.sv
`timescale 1ns/1ps
// EMIF write front end: synchronises and filters the async EMIF strobes,
// latches address/data and produces a clean write window plus debug stats.
module emif_wr_frontend #(
    parameter int FILTER_LEN = 3,
    parameter int MIN_ACTIVE = 6,
    parameter int TIMEOUT    = 1023,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              emif_ce_n,
    input  logic              emif_we_n,
    input  logic [ADDR_W-1:0] emif_addr,
    input  logic [DATA_W-1:0] emif_data,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [15:0]       wr_count,
    output logic [7:0]        glitch_cnt,
    output logic              short_err,
    output logic              timeout_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int AW = $clog2(TIMEOUT + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [AW-1:0] ACT_MAX   = AW'(TIMEOUT);
    localparam logic [AW-1:0] ACT_MIN   = AW'(MIN_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUAL,
        S_ACTIVE,
        S_RELEASE,
        S_FAULT
    } state_t;

    state_t state, state_d;

    logic              ce_s1, ce_s2;
    logic              we_s1, we_s2;
    logic [DATA_W-1:0] data_s1;
    logic              strobe_s;

    logic [FW-1:0]     filt_cnt, filt_d;
    logic [AW-1:0]     act_cnt, act_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       count_d;
    logic [7:0]        glitch_d;
    logic              short_d, timeout_d;
    logic              glitch_inc, short_set, timeout_set;

    // Two-flop synchronisers for the strobes and the data bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_s1   <= 1'b1;
            ce_s2   <= 1'b1;
            we_s1   <= 1'b1;
            we_s2   <= 1'b1;
            data_s1 <= '0;
            wr_data <= '0;
        end else begin
            ce_s1   <= emif_ce_n;
            ce_s2   <= ce_s1;
            we_s1   <= emif_we_n;
            we_s2   <= we_s1;
            data_s1 <= emif_data;
            wr_data <= data_s1;
        end
    end

    assign strobe_s = ~ce_s2 & ~we_s2;

    // Window FSM state, filter/active counters, latched address and stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            filt_cnt    <= '0;
            act_cnt     <= '0;
            wr_addr     <= '0;
            wr_count    <= '0;
            glitch_cnt  <= '0;
            short_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            filt_cnt    <= filt_d;
            act_cnt     <= act_d;
            wr_addr     <= addr_d;
            wr_count    <= count_d;
            glitch_cnt  <= glitch_d;
            short_err   <= short_d;
            timeout_err <= timeout_d;
        end
    end

    // Next-state logic; a set/increment in the same cycle as err_clr wins.
    always_comb begin
        state_d     = state;
        filt_d      = filt_cnt;
        act_d       = act_cnt;
        addr_d      = wr_addr;
        count_d     = wr_count;
        glitch_inc  = 1'b0;
        short_set   = 1'b0;
        timeout_set = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (strobe_s) begin
                    state_d = S_QUAL;
                    filt_d  = FILT_ONE;
                end
            end
            S_QUAL: begin
                if (!strobe_s) begin
                    state_d    = S_IDLE;
                    glitch_inc = 1'b1;
                end else if (filt_cnt == FILT_LAST) begin
                    state_d = S_ACTIVE;
                    act_d   = '0;
                    addr_d  = emif_addr;
                end else begin
                    filt_d = filt_cnt + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!strobe_s) begin
                    state_d = S_RELEASE;
                    filt_d  = FILT_ONE;
                end else if (act_cnt == ACT_MAX) begin
                    state_d     = S_FAULT;
                    timeout_set = 1'b1;
                    filt_d      = '0;
                end else begin
                    act_d = act_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (strobe_s) begin
                    state_d = S_ACTIVE;
                end else if (filt_cnt == FILT_LAST) begin
                    state_d = S_IDLE;
                    if (act_cnt < ACT_MIN) begin
                        short_set = 1'b1;
                    end else begin
                        count_d = wr_count + 16'd1;
                    end
                end else begin
                    filt_d = filt_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                if (strobe_s) begin
                    filt_d = '0;
                end else if (filt_cnt == FILT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    filt_d = filt_cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_clr) begin
            glitch_d = glitch_inc ? 8'd1 : 8'd0;
        end else if (glitch_inc && glitch_cnt != 8'hFF) begin
            glitch_d = glitch_cnt + 8'd1;
        end else begin
            glitch_d = glitch_cnt;
        end

        short_d   = short_set | (short_err & ~err_clr);
        timeout_d = timeout_set | (timeout_err & ~err_clr);
    end

    // Write window is decoded straight from the state register.
    assign wr_en = (state == S_ACTIVE) || (state == S_RELEASE);

endmodule

// File: tb/tb_emif_wr_frontend.sv
`timescale 1ns/1ps
// Scoreboarded bench for emif_wr_frontend: expected windows are queued
// when strobes are driven and checked when wr_en rises.
module tb_emif_wr_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_n, we_n;
    logic [12:0] addr;
    logic [15:0] data;
    logic        err_clr;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] wr_count;
    logic [7:0]  glitch_cnt;
    logic        short_err, timeout_err;

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic prev_en = 1'b0;

    emif_wr_frontend dut (
        .clk        (clk),
        .rst        (rst),
        .emif_ce_n  (ce_n),
        .emif_we_n  (we_n),
        .emif_addr  (addr),
        .emif_data  (data),
        .err_clr    (err_clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_count   (wr_count),
        .glitch_cnt (glitch_cnt),
        .short_err  (short_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each rising wr_en must match the oldest queued window.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1 && prev_en !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_win", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("win_addr", 32'(wr_addr), 32'(e.a));
                chk("win_data", 32'(wr_data), 32'(e.d));
            end
        end
        prev_en = wr_en;
    end

    task automatic do_write(input logic [12:0] a, input logic [15:0] d,
                            input int n);
        @(negedge clk);
        sb.push_back('{a: a, d: d});
        addr = a;
        data = d;
        ce_n = 1'b0;
        we_n = 1'b0;
        repeat (n) @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic glitch(input logic clr);
        @(negedge clk);
        ce_n = 1'b0;
        we_n = 1'b0;
        repeat (2) @(negedge clk);
        we_n = 1'b1;
        repeat (2) @(negedge clk);
        err_clr = clr;
        @(negedge clk);
        err_clr = 1'b0;
        ce_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   fall_at;
        logic seen;
        logic any_hi;

        rst     = 1'b1;
        ce_n    = 1'b1;
        we_n    = 1'b1;
        addr    = '0;
        data    = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_glitch", 32'(glitch_cnt), 32'd0);
        chk("rst_short", 32'(short_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic 40-cycle write with rise/fall latency
        sb.push_back('{a: 13'h0003, d: 16'h0015});
        addr = 13'h0003;
        data = 16'h0015;
        ce_n = 1'b0;
        we_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 chk("rise_lat", 32'(wr_en), 32'(k == 5));
        end
        repeat (35) @(posedge clk);
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 chk("fall_lat", 32'(wr_en), 32'(k < 5));
        end
        @(negedge clk);
        chk("t1_count", 32'(wr_count), 32'd1);
        chk("t1_addr", 32'(wr_addr), 32'h0003);
        chk("t1_data", 32'(wr_data), 32'h0015);
        chk("t1_short", 32'(short_err), 32'd0);
        chk("t1_timeout", 32'(timeout_err), 32'd0);

        // Two-cycle we_n glitch
        glitch(1'b0);
        chk("gl_cnt", 32'(glitch_cnt), 32'd1);
        chk("gl_wr_en", 32'(wr_en), 32'd0);

        // Short window (5 ACTIVE cycles) then the legal boundary (6)
        do_write(13'h0100, 16'h0A0A, 8);
        chk("short_set", 32'(short_err), 32'd1);
        chk("short_count", 32'(wr_count), 32'd1);
        clr_pulse();
        chk("clr_short", 32'(short_err), 32'd0);
        chk("clr_glitch", 32'(glitch_cnt), 32'd0);
        do_write(13'h0101, 16'h0B0B, 9);
        chk("min_short", 32'(short_err), 32'd0);
        chk("min_count", 32'(wr_count), 32'd2);

        // Stuck strobe -> FAULT
        @(negedge clk);
        sb.push_back('{a: 13'h1ABC, d: 16'h0F0F});
        addr = 13'h1ABC;
        data = 16'h0F0F;
        ce_n = 1'b0;
        we_n = 1'b0;
        fall_at = 0;
        seen = 1'b0;
        for (int e = 1; e <= 2000; e++) begin
            @(posedge clk);
            #1;
            if (wr_en) seen = 1'b1;
            else if (seen && fall_at == 0) fall_at = e;
        end
        chk("to_fall_edge", 32'(fall_at), 32'd1029);
        chk("to_flag", 32'(timeout_err), 32'd1);
        chk("to_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        any_hi = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 any_hi |= wr_en;
        end
        chk("fault_exit_en", 32'(any_hi), 32'd0);
        chk("to_count", 32'(wr_count), 32'd2);
        clr_pulse();
        chk("clr_timeout", 32'(timeout_err), 32'd0);
        do_write(13'h0042, 16'h4242, 12);
        chk("post_fault_cnt", 32'(wr_count), 32'd3);

        // One-cycle we_n blip inside ACTIVE
        @(negedge clk);
        sb.push_back('{a: 13'h00AB, d: 16'h1234});
        addr = 13'h00AB;
        data = 16'h1234;
        ce_n = 1'b0;
        we_n = 1'b0;
        repeat (12) @(negedge clk);
        we_n = 1'b1;
        addr = 13'h1FFF;
        @(negedge clk);
        we_n = 1'b0;
        repeat (12) @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("blip_addr", 32'(wr_addr), 32'h00AB);
        chk("blip_count", 32'(wr_count), 32'd4);
        chk("blip_short", 32'(short_err), 32'd0);

        glitch(1'b0);
        chk("gl2_cnt", 32'(glitch_cnt), 32'd1);

        // Reset in the middle of ACTIVE, strobe kept low
        @(negedge clk);
        sb.push_back('{a: 13'h0555, d: 16'hBEEF});
        addr = 13'h0555;
        data = 16'hBEEF;
        ce_n = 1'b0;
        we_n = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_count", 32'(wr_count), 32'd0);
        chk("arst_glitch", 32'(glitch_cnt), 32'd0);
        sb.push_back('{a: 13'h0555, d: 16'hBEEF});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 chk("rst_requal", 32'(wr_en), 32'(k == 5));
        end
        repeat (20) @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rq_count", 32'(wr_count), 32'd1);
        chk("rq_addr", 32'(wr_addr), 32'h0555);

        // err_clr coincident with a glitch increment
        glitch(1'b0);
        chk("gl3_cnt", 32'(glitch_cnt), 32'd1);
        glitch(1'b1);
        chk("gl_clr_race", 32'(glitch_cnt), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
